// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types for the schedule-table controller
package sched_pkg;

   localparam int ENTRY_W = 18;

   typedef enum logic [1:0] {
      NOP  = 2'd0,
      ALU  = 2'd1,
      MUL  = 2'd2,
      RSVD = 2'd3
   } unit_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Field order is MSB first so the struct overlays cfg_data bit-for-bit.
   typedef struct packed {
      logic       last;
      logic       res;
      logic       dst_en;
      logic [3:0] dst;
      logic       op;
      logic [3:0] sel2;
      logic [3:0] sel1;
      unit_e      unit;
   } sched_entry_t;

endpackage

// File: rtl/sched_entry_decode.sv
// rtl/sched_entry_decode.sv - combinational decode of one schedule entry
module sched_entry_decode
   import sched_pkg::*;
#(
   parameter int NUM_REGS = 12,
   parameter int SEL_W    = 4
) (
   input  sched_entry_t        entry_i,
   input  logic                valid_i,
   output logic [SEL_W-1:0]    alu1_sel1_o,
   output logic [SEL_W-1:0]    alu1_sel2_o,
   output logic                alu1_op_o,
   output logic [SEL_W-1:0]    mul1_sel1_o,
   output logic [SEL_W-1:0]    mul1_sel2_o,
   output logic                mul1_op_o,
   output logic [NUM_REGS-1:0] reg_en_o,
   output logic                result_en_o,
   output logic                last_o
);

   always_comb begin
      alu1_sel1_o = '0;
      alu1_sel2_o = '0;
      alu1_op_o   = 1'b0;
      mul1_sel1_o = '0;
      mul1_sel2_o = '0;
      mul1_op_o   = 1'b0;
      reg_en_o    = '0;
      result_en_o = 1'b0;
      last_o      = entry_i.last;
      if (valid_i) begin
         case (entry_i.unit)
            ALU: begin
               alu1_sel1_o = SEL_W'(entry_i.sel1);
               alu1_sel2_o = SEL_W'(entry_i.sel2);
               alu1_op_o   = entry_i.op;
            end
            MUL: begin
               mul1_sel1_o = SEL_W'(entry_i.sel1);
               mul1_sel2_o = SEL_W'(entry_i.sel2);
               mul1_op_o   = entry_i.op;
            end
            default: ;
         endcase
         // Destinations beyond NUM_REGS match no bit and so enable nothing.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (entry_i.dst_en && (32'(entry_i.dst) == i)) reg_en_o[i] = 1'b1;
         end
         result_en_o = entry_i.res;
      end
   end

endmodule

// File: rtl/sched_table_controller.sv
// rtl/sched_table_controller.sv - table-driven schedule sequencer for the shared ALU/MUL datapath
// Optional run_cycles counter enabled by SCHED_CYCLE_CNT_EN.
module sched_table_controller
   import sched_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int NUM_REGS = 12,
   parameter int SEL_W    = 4,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic                cfg_we,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [ENTRY_W-1:0]  cfg_data,
   output logic                cfg_err,
   output logic                op_ready,
   output logic                busy,
   output logic                done_next,
   output logic                result_en,
   output logic [SEL_W-1:0]    alu1_sel1,
   output logic [SEL_W-1:0]    alu1_sel2,
   output logic                alu1_op,
   output logic [SEL_W-1:0]    mul1_sel1,
   output logic [SEL_W-1:0]    mul1_sel2,
   output logic                mul1_op,
`ifdef SCHED_CYCLE_CNT_EN
   output logic [15:0]         run_cycles,
`endif
   output logic [NUM_REGS-1:0] reg_en
);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               cfg_err_q;
   sched_entry_t       table_q [DEPTH];
   logic               cur_last;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            pc_d    = '0;
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               pc_d    = '0;
            end else if (cur_last || (pc_q == ADDR_W'(DEPTH - 1))) begin
               state_d = DONE;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            pc_d    = '0;
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cfg_err_q <= cfg_we && (state_q != IDLE);
         if (cfg_we && (state_q == IDLE)) table_q[cfg_addr] <= sched_entry_t'(cfg_data);
      end
   end

`ifdef SCHED_CYCLE_CNT_EN
   logic [15:0] run_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cycles_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         run_cycles_q <= '0;
      end else if ((state_q == RUN) && (run_cycles_q != 16'hFFFF)) begin
         run_cycles_q <= run_cycles_q + 16'd1;
      end
   end

   assign run_cycles = run_cycles_q;
`endif

   assign cfg_err   = cfg_err_q;
   assign op_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign done_next = (state_q == DONE);

   // An aborting cycle still counts as RUN but drives nothing into the datapath.
   sched_entry_decode #(
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
   ) u_decode (
      .entry_i     (table_q[pc_q]),
      .valid_i     ((state_q == RUN) && !abort),
      .alu1_sel1_o (alu1_sel1),
      .alu1_sel2_o (alu1_sel2),
      .alu1_op_o   (alu1_op),
      .mul1_sel1_o (mul1_sel1),
      .mul1_sel2_o (mul1_sel2),
      .mul1_op_o   (mul1_op),
      .reg_en_o    (reg_en),
      .result_en_o (result_en),
      .last_o      (cur_last)
   );

endmodule

// File: tb/tb_sched_table_controller.sv
// tb/tb_sched_table_controller.sv - directed bench for sched_table_controller
module tb_sched_table_controller;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [17:0] cfg_data;
   logic        cfg_err;
   logic        op_ready;
   logic        busy;
   logic        done_next;
   logic        result_en;
   logic [3:0]  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2;
   logic        alu1_op, mul1_op;
   logic [11:0] reg_en;
`ifdef SCHED_CYCLE_CNT_EN
   logic [15:0] run_cycles;
`endif

   int vectors = 0;
   int errs    = 0;

   int eu [16], es1 [16], es2 [16], eop [16], edst [16], eden [16], eres [16];

   sched_table_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .op_ready  (op_ready),
      .busy      (busy),
      .done_next (done_next),
      .result_en (result_en),
      .alu1_sel1 (alu1_sel1),
      .alu1_sel2 (alu1_sel2),
      .alu1_op   (alu1_op),
      .mul1_sel1 (mul1_sel1),
      .mul1_sel2 (mul1_sel2),
      .mul1_op   (mul1_op),
`ifdef SCHED_CYCLE_CNT_EN
      .run_cycles(run_cycles),
`endif
      .reg_en    (reg_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] mk(input int u, s1, s2, op, dst, den, res, last);
      mk = {last[0], res[0], den[0], dst[3:0], op[0], s2[3:0], s1[3:0], u[1:0]};
   endfunction

   task automatic set_exp(input int k, u, s1, s2, op, dst, den, res);
      eu[k] = u; es1[k] = s1; es2[k] = s2; eop[k] = op;
      edst[k] = dst; eden[k] = den; eres[k] = res;
   endtask

   task automatic clear_exp();
      for (int k = 0; k < 16; k++) set_exp(k, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_asel"}, {alu1_sel1, alu1_sel2, 3'b0, alu1_op}, 0);
      chk({tag, "_msel"}, {mul1_sel1, mul1_sel2, 3'b0, mul1_op}, 0);
      chk({tag, "_regen"}, reg_en, 0);
      chk({tag, "_res"}, result_en, 0);
   endtask

   task automatic chk_step(input int k);
      logic [31:0] re;
      re = (eden[k] != 0 && edst[k] < 12) ? (32'd1 << edst[k]) : 32'd0;
      chk("run_busy", busy, 1);
      chk("run_done", done_next, 0);
      chk("run_alu1", alu1_sel1, eu[k] == 1 ? es1[k] : 0);
      chk("run_alu2", alu1_sel2, eu[k] == 1 ? es2[k] : 0);
      chk("run_aluop", alu1_op, eu[k] == 1 ? eop[k] : 0);
      chk("run_mul1", mul1_sel1, eu[k] == 2 ? es1[k] : 0);
      chk("run_mul2", mul1_sel2, eu[k] == 2 ? es2[k] : 0);
      chk("run_mulop", mul1_op, eu[k] == 2 ? eop[k] : 0);
      chk("run_regen", reg_en, re);
      chk("run_res", result_en, eres[k]);
   endtask

   task automatic wr(input int addr, input logic [17:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_data = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Start is applied at the first negedge; cfg_we already set by the caller is kept for that cycle.
   task automatic run_prog(input int n);
      @(negedge clk);
      start = 1'b1;
      #1 chk("idle_ready", op_ready, 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start = 1'b0; cfg_we = 1'b0;
         #1 chk_step(k);
      end
      @(negedge clk);
      #1;
      chk("done_pulse", done_next, 1);
      chk("done_busy", busy, 0);
      chk_quiet("done");
      @(negedge clk);
      #1;
      chk("post_ready", op_ready, 1);
      chk("post_done", done_next, 0);
   endtask

   task automatic load_six();
      wr(0, mk(2, 0, 1, 0, 0, 1, 0, 0));
      wr(1, mk(1, 7, 2, 0, 1, 1, 0, 0));
      wr(2, mk(2, 8, 3, 0, 2, 1, 0, 0));
      wr(3, mk(1, 9, 4, 1, 3, 1, 0, 0));
      wr(4, mk(2, 10, 5, 1, 4, 1, 0, 0));
      wr(5, mk(1, 11, 6, 0, 5, 1, 1, 1));
      clear_exp();
      set_exp(0, 2, 0, 1, 0, 0, 1, 0);
      set_exp(1, 1, 7, 2, 0, 1, 1, 0);
      set_exp(2, 2, 8, 3, 0, 2, 1, 0);
      set_exp(3, 1, 9, 4, 1, 3, 1, 0);
      set_exp(4, 2, 10, 5, 1, 4, 1, 0);
      set_exp(5, 1, 11, 6, 0, 5, 1, 1);
   endtask

   initial begin
      int waited;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_next, 0);
      chk("rst_err", cfg_err, 0);
      chk_quiet("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Empty table: full-depth run with nothing driven
      clear_exp();
      run_prog(16);

      // Six-entry program
      load_six();
      run_prog(6);
`ifdef SCHED_CYCLE_CNT_EN
      chk("run_cycles", run_cycles, 6);
`endif

      // Write during RUN is dropped and flagged
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = mk(2, 15, 15, 1, 7, 1, 1, 1);
      @(negedge clk);
      cfg_we = 1'b0;
      #1 chk("cfg_err_pulse", cfg_err, 1);
      @(negedge clk);
      #1 chk("cfg_err_clear", cfg_err, 0);
      waited = 0;
      while (!op_ready && waited < 20) begin
         @(negedge clk);
         #1 waited++;
      end
      chk("drop_run_end", op_ready, 1);
      run_prog(6);

      // Abort at pc=2
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 chk_step(0);
      @(negedge clk);
      #1 chk_step(1);
      @(negedge clk);
      abort = 1'b1;
      #1;
      chk("abort_busy", busy, 1);
      chk_quiet("abort");
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_idle", op_ready, 1);
      chk("abort_nodone", done_next, 0);
      @(negedge clk);
      #1 chk("abort_nodone2", done_next, 0);

      // Asynchronous reset at pc=4 clears the table
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 chk_step(4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", op_ready, 1);
      chk("arst_busy", busy, 0);
      chk_quiet("arst");
      @(negedge clk);
      rst_n = 1'b1;
      clear_exp();
      run_prog(16);

      // Reserved unit, out-of-range destination, written in the same cycle as start
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = mk(3, 5, 6, 1, 13, 1, 0, 1);
      clear_exp();
      set_exp(0, 3, 5, 6, 1, 13, 1, 0);
      run_prog(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/sched_table_controller.md
Name: sched_table_controller

Overview:
- Programmable replacement for the hard-wired, per-schedule controller FSMs that drive the shared single-ALU/single-MUL datapath.
- Steps through a small schedule table, one entry per cycle, and drives mux selects, op codes and destination register enables.
- The table is loaded through a config write port. This lets one RTL instance execute any scheduled dataflow graph that fits in DEPTH steps.

Parameters:
- DEPTH, 16, number of schedule entries (power of 2, at least 2)
- NUM_REGS, 12, number of datapath intermediate registers (one-hot enable vector width)
- SEL_W, 4, width of each operand mux select
- ADDR_W, $clog2(DEPTH), table address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin schedule execution; sampled in IDLE only
- abort  in  1  terminate a run; sampled in RUN only
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  table write address
- cfg_data  in  18  table entry (format below)
- cfg_err  out  1  one-cycle pulse when a write is dropped
- op_ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done_next  out  1  one-cycle pulse in DONE
- result_en  out  1  load the datapath result register this cycle
- alu1_sel1, alu1_sel2  out  SEL_W  ALU operand selects
- alu1_op  out  1  ALU op (0 add, 1 sub)
- mul1_sel1, mul1_sel2  out  SEL_W  MUL operand selects
- mul1_op  out  1  MUL op
- reg_en  out  NUM_REGS  one-hot destination register enable

Behaviour:
- Entry format:
  - [1:0] unit: 0 nop, 1 alu, 2 mul, 3 reserved (decoded as nop)
  - [5:2] sel1, [9:6] sel2, [10] op, [14:11] dst, [15] dst_en, [16] res, [17] last
- Table storage:
  - Flops, cleared to all-zero by reset; an all-zero entry is a nop with last=0.
  - Write occurs on the clock edge when cfg_we=1 and state==IDLE.
  - cfg_we in RUN or DONE: write dropped, cfg_err=1 the next cycle.
- Reset: state=IDLE, pc=0, cfg_err=0. All decoded outputs are 0 except op_ready=1.
- FSM, states IDLE, RUN, DONE:
  - IDLE: op_ready=1. start=1 -> RUN with pc=0. If cfg_we and start occur in the same cycle, the write is performed and the run starts.
  - RUN: outputs decode combinationally from table[pc].
    - unit=1 drives alu1_* from sel1/sel2/op; mul1_* stay 0.
    - unit=2 drives mul1_* likewise; alu1_* stay 0.
    - reg_en[dst]=1 when dst_en=1 and dst<NUM_REGS; dst>=NUM_REGS gives no enable.
    - result_en=res.
    - Exit: last=1 or pc==DEPTH-1 -> DONE; otherwise pc<=pc+1. pc never wraps.
  - RUN with abort=1: all decoded outputs forced to 0 that cycle; next state IDLE, pc=0, no done_next. Abort takes priority over last.
  - DONE: done_next=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency: a schedule of N entries (last at index N-1) gives start to done_next = N+1 cycles. done_next is followed by op_ready one cycle later.
- Reset mid-run: immediate return to IDLE and table cleared; reprogramming is required.
- All unused select/op outputs are 0 in every non-RUN state.

Optional Feature:
- SCHED_CYCLE_CNT_EN.
- Defined:
  - Adds output run_cycles[15:0]: cleared on entry to RUN, incremented each RUN cycle, saturating at 16'hFFFF.
  - Holds its value in DONE and IDLE until the next start; reset value 0.
  - Aborted runs leave the partial count.
- Undefined: the port is absent and no counter logic is generated.

Decomposition:
- Package sched_pkg holds:
  - unit_e enum (NOP, ALU, MUL, RSVD)
  - sched_entry_t packed struct matching the bit layout
  - state_e (IDLE, RUN, DONE)
  - ENTRY_W=18
- One sub-module, sched_entry_decode: purely combinational. It maps an entry plus a valid flag to the select/op/reg_en/result_en outputs.
- The FSM, pc and table live in the top module.

Test Plan:
- Six-entry program:
  - mul(0,1)->r0, alu(7,2)->r1, mul(8,3)->r2, alu(9,4)->r3, mul(10,5)->r4, alu(11,6)->r5 with res+last.
  - Required: exact per-cycle selects; reg_en=1,2,4,8,16,32; result_en only on cycle 6; done_next 7 cycles after start.
- Empty table after reset, start -> 16 RUN cycles with all outputs 0, done_next at cycle 17.
- cfg_we during RUN at addr 3 -> cfg_err pulse; table[3] unchanged, verified by rerunning.
- abort asserted in RUN at pc=2 of the six-entry program -> outputs 0 that cycle, IDLE next, no done_next.
- Entry with dst=13, dst_en=1, unit=3 -> reg_en=0, alu/mul selects 0.
- rst_n low at pc=4 -> asynchronous return to IDLE, op_ready=1, table zeroed. With SCHED_CYCLE_CNT_EN, run_cycles=6 after a normal six-entry run.
